// File: rtl/seq_det_pkg.sv
// Shared constants and types for the programmable serial pattern detector.
// Reset configuration reproduces the legacy fixed 101101 overlapping detector.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

  typedef logic [LEN_W-1:0] len_t;

  localparam logic [MAX_LEN_DEF-1:0] DEF_PATTERN_C = 8'b0010_1101;
  localparam int                     DEF_LEN_C     = 6;
  localparam logic                   DEF_OVERLAP_C = 1'b1;

  // A zero-length pattern, or one longer than the history, can never be matched.
  function automatic logic len_bad(input int len, input int max_len);
    return (len == 0) || (len > max_len);
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked comparator: candidate equals pattern over the low len bits.
module seq_det_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LW      = 4
) (
  input  logic [MAX_LEN-1:0] cand,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  output logic               eq
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
  end

  assign eq = (((cand ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a zero-latency Mealy match pulse,
// saturating match counter and config-error flag.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEF_PATTERN_C,
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = DEF_OVERLAP_C
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             ip,
  input  logic                             cfg_we,
  input  logic [MAX_LEN-1:0]               cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
  input  logic                             cfg_overlap,
  input  logic                             cnt_clr,
  output logic                             op,
  output logic [CNT_W-1:0]                 match_cnt,
  output logic                             cfg_err
);

  localparam int               LW      = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The oldest of MAX_LEN history bits is never part of a candidate, so it is not stored.
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;

  logic [MAX_LEN-1:0] cand;
  logic [LW:0]        fill_p1;
  logic               fill_ok;
  logic               eq;
  logic               match;

  assign cand    = {hist, ip};
  assign fill_p1 = {1'b0, fill} + (LW+1)'(1);
  assign fill_ok = (fill_p1 >= {1'b0, len_q});

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_cmp (
    .cand    (cand),
    .pattern (pat_q),
    .len     (len_q),
    .eq      (eq)
  );

  // rst_n gates the pulse so a short default pattern cannot fire while held in reset.
  assign match = rst_n & en & ~cfg_we & ~cfg_err & fill_ok & eq;
  assign op    = match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      hist    <= '0;
      fill    <= '0;
      pat_q   <= cfg_pattern;
      len_q   <= cfg_len;
      ovl_q   <= cfg_overlap;
      cfg_err <= len_bad(int'(cfg_len), MAX_LEN);
    end else if (en) begin
      if (match && !ovl_q) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= cand[MAX_LEN-2:0];
        if (fill != LW'(MAX_LEN)) begin
          fill <= fill + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised bench for seq_detector_prog against a queue-based model of the matching rules.
module tb_seq_detector_prog;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ip;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  len_t       cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       op;
  logic [7:0] match_cnt;
  logic       cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: received valid bits since the last clear, oldest first.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_err;
  int         m_cnt;

  seq_detector_prog dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ip          (ip),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .op          (op),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_match();
    int sz;
    bit b;
    if (!rst_n || !en || cfg_we || m_err || m_len < 1) return 1'b0;
    sz = mq.size();
    if (sz < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? ip : mq[sz - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat = 8'b0010_1101;
    m_len = 6;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_update(input bit mt);
    if (cfg_we) begin
      m_pat = cfg_pattern;
      m_len = int'(cfg_len);
      m_ovl = cfg_overlap;
      m_err = (m_len == 0) || (m_len > 8);
      mq.delete();
    end else if (en) begin
      if (mt && !m_ovl) begin
        mq.delete();
      end else begin
        mq.push_back(ip);
        if (mq.size() > 8) void'(mq.pop_front());
      end
    end
    if (cnt_clr) m_cnt = 0;
    else if (mt && m_cnt < 255) m_cnt++;
  endtask

  // Inputs change just after each rising edge; the falling edge sees them settled.
  initial begin
    bit exp_op;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        exp_op = model_match();
        check("op_model", op, exp_op);
        check("cnt_model", match_cnt, m_cnt);
        check("err_model", cfg_err, m_err);
        model_update(exp_op);
      end
    end
  end

  task automatic tick(input bit e, input bit b, input bit we, input bit clr, output bit o);
    en      = e;
    ip      = b;
    cfg_we  = we;
    cnt_clr = clr;
    @(negedge clk);
    o = op;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit e, input bit b, output bit o);
    tick(e, b, 1'b0, 1'b0, o);
  endtask

  task automatic load(input logic [7:0] p, input len_t l, input bit ov, input bit clr);
    bit o;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    tick(1'b1, 1'($urandom), 1'b1, clr, o);
    check("cfg_cycle_op", o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         o;
    bit         any;
    logic [8:0] stream;
    logic [8:0] hits;
    logic [4:0] v;
    int         saved;
    len_t       rl;

    rst_n = 1'b0; en = 1'b0; ip = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_op", op, 0);
    check("reset_cnt", match_cnt, 0);
    check("reset_err", cfg_err, 0);

    // Default 101101 overlapping
    stream = 9'b1_0110_1101;
    hits = '0;
    for (int k = 0; k < 9; k++) begin send(1'b1, stream[8-k], o); hits[k] = o; end
    check("def_overlap_hits", hits, 9'b1_0010_0000);
    check("def_overlap_cnt", match_cnt, 2);

    // Same stream, non-overlapping
    load(8'h2D, 4'd6, 1'b0, 1'b1);
    hits = '0;
    for (int k = 0; k < 9; k++) begin send(1'b1, stream[8-k], o); hits[k] = o; end
    check("nonoverlap_hits", hits, 9'b0_0010_0000);
    check("nonoverlap_cnt", match_cnt, 1);

    // 111 with gapped enable
    load(8'h07, 4'd3, 1'b1, 1'b0);
    any = 1'b0;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b1, o); v[k] = o;
      send(1'b0, 1'b0, o); any |= o;
    end
    check("gapped_hits", v, 5'b11100);
    check("gap_op", any, 0);

    // Reconfiguration mid-pattern discards history
    load(8'h2D, 4'd6, 1'b1, 1'b0);
    stream = 9'b0_0001_0110;
    for (int k = 0; k < 5; k++) send(1'b1, stream[4-k], o);
    load(8'h2D, 4'd6, 1'b1, 1'b0);
    send(1'b1, 1'b1, o);
    check("after_cfg_no_match", o, 0);
    send(1'b1, 1'b0, o); send(1'b1, 1'b1, o); send(1'b1, 1'b1, o); send(1'b1, 1'b0, o);
    send(1'b1, 1'b1, o);
    check("fresh_six_match", o, 1);

    // Invalid lengths
    load(8'hFF, 4'd9, 1'b1, 1'b0);
    check("len9_err", cfg_err, 1);
    load(8'h00, 4'd0, 1'b1, 1'b0);
    check("len0_err", cfg_err, 1);
    saved = match_cnt;
    any = 1'b0;
    for (int k = 0; k < 20; k++) begin send(1'b1, 1'($urandom), o); any |= o; end
    check("err_no_op", any, 0);
    check("err_cnt_hold", match_cnt, saved);
    load(8'h02, 4'd2, 1'b1, 1'b0);
    check("len2_err_clear", cfg_err, 0);
    send(1'b1, 1'b1, o);
    send(1'b1, 1'b0, o);
    check("len2_match", o, 1);

    // len=1 and counter saturation
    load(8'h01, 4'd1, 1'b1, 1'b1);
    check("cnt_cleared", match_cnt, 0);
    send(1'b1, 1'b0, o);
    check("len1_zero_no_match", o, 0);
    for (int k = 1; k <= 3; k++) begin
      send(1'b1, 1'b1, o);
      check("len1_count", match_cnt, k);
    end
    for (int k = 0; k < 300; k++) send(1'b1, 1'b1, o);
    check("cnt_saturated", match_cnt, 255);
    tick(1'b1, 1'b1, 1'b0, 1'b1, o);
    check("clr_with_match_op", o, 1);
    check("clr_with_match_cnt", match_cnt, 0);

    // Randomised configurations and traffic
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 9) == 0) rl = len_t'($urandom_range(9, 15)) & 4'hF;
      else if ($urandom_range(0, 1) == 0) rl = len_t'($urandom_range(1, 3));
      else rl = len_t'($urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) rl = '0;
      load(8'($urandom), rl, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      for (int k = 0; k < 40; k++) begin
        tick(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
             ($urandom_range(0, 49) == 0), o);
      end
    end

    // Asynchronous reset in the middle of a cycle
    load(8'h01, 4'd1, 1'b1, 1'b1);
    send(1'b1, 1'b1, o);
    load(8'h00, 4'd0, 1'b1, 1'b0);
    check("pre_reset_cnt", match_cnt, 1);
    check("pre_reset_err", cfg_err, 1);
    en = 1'b1; ip = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_op", op, 0);
    check("async_rst_cnt", match_cnt, 0);
    check("async_rst_err", cfg_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b1, 1'b1, o);
    check("post_reset_no_op", o, 0);
    for (int k = 0; k < 10; k++) send(1'b1, 1'($urandom), o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
